ascon_permutation_simple: RTL and testbench

- One Ascon permutation round per clock over a 320-bit state: constant addition, 5-bit S-box substitution layer, linear diffusion layer.
- The result goes into an internal state register. A mux selects either the external input state or the registered state as the round input, so 12 consecutive enabled cycles perform p12.
- Datapath core of the Ascon-128 AEAD; sequencing (round counter, mode select) comes from an external FSM.

---
 rtl/ascon_permutation_simple.sv | 96 +++++++++
 tb/tb_ascon_permutation_simple.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ascon_permutation_simple.sv
// One Ascon round per enabled clock over a 320-bit state (x0..x4 = word [0]..[4]).
// The input mux picks the external state or the registered state as the round input.
module ascon_permutation_simple (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic [0:4][63:0] permutation_i,
  input  logic             input_mode_i,
  input  logic [3:0]       round_i,
  input  logic             enable_i,
  output logic [0:4][63:0] permutation_o
);

  logic [0:4][63:0] state_reg;
  logic [0:4][63:0] round_in;
  logic [0:4][63:0] const_out;
  logic [0:4][63:0] sbox_out;
  logic [0:4][63:0] lin_out;
  logic [7:0]       round_const;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  always_comb begin
    round_const = 8'h00;
    case (round_i)
      4'd0:  round_const = 8'hF0;
      4'd1:  round_const = 8'hE1;
      4'd2:  round_const = 8'hD2;
      4'd3:  round_const = 8'hC3;
      4'd4:  round_const = 8'hB4;
      4'd5:  round_const = 8'hA5;
      4'd6:  round_const = 8'h96;
      4'd7:  round_const = 8'h87;
      4'd8:  round_const = 8'h78;
      4'd9:  round_const = 8'h69;
      4'd10: round_const = 8'h5A;
      4'd11: round_const = 8'h4B;
      default: round_const = 8'h00;
    endcase
  end

  always_comb begin
    round_in = input_mode_i ? permutation_i : state_reg;
    const_out = round_in;
    const_out[2][7:0] = round_in[2][7:0] ^ round_const;
  end

  // Bitsliced form of the 5-bit S-box, evaluated on all 64 columns at once.
  always_comb begin
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    a0 = const_out[0] ^ const_out[4];
    a4 = const_out[4] ^ const_out[3];
    a2 = const_out[2] ^ const_out[1];
    a1 = const_out[1];
    a3 = const_out[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    sbox_out[0] = a0;
    sbox_out[1] = a1;
    sbox_out[2] = a2;
    sbox_out[3] = a3;
    sbox_out[4] = a4;
  end

  always_comb begin
    lin_out[0] = sbox_out[0] ^ ror64(sbox_out[0], 19) ^ ror64(sbox_out[0], 28);
    lin_out[1] = sbox_out[1] ^ ror64(sbox_out[1], 61) ^ ror64(sbox_out[1], 39);
    lin_out[2] = sbox_out[2] ^ ror64(sbox_out[2], 1)  ^ ror64(sbox_out[2], 6);
    lin_out[3] = sbox_out[3] ^ ror64(sbox_out[3], 10) ^ ror64(sbox_out[3], 17);
    lin_out[4] = sbox_out[4] ^ ror64(sbox_out[4], 7)  ^ ror64(sbox_out[4], 41);
  end

  always_ff @(posedge clock_i) begin
    if (resetb_i)
      state_reg <= '0;
    else if (enable_i)
      state_reg <= lin_out;
  end

  assign permutation_o = state_reg;

endmodule

// File: tb/tb_ascon_permutation_simple.sv
// Self-checking bench for ascon_permutation_simple against a table-driven round model.
module tb_ascon_permutation_simple;

  typedef logic [0:4][63:0] state_t;

  logic       clk = 1'b0;
  logic       rst;
  state_t     pin;
  logic       mode;
  logic [3:0] rnd;
  logic       en;
  state_t     pout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  state_t      model;
  state_t      saved;

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

  localparam int ROT_A [0:4] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [0:4] = '{28, 39, 6, 17, 41};

  ascon_permutation_simple dut (
    .clock_i       (clk),
    .resetb_i      (rst),
    .permutation_i (pin),
    .input_mode_i  (mode),
    .round_i       (rnd),
    .enable_i      (en),
    .permutation_o (pout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [63:0] y;
    for (int b = 0; b < 64; b++) y[b] = x[(b + n) % 64];
    return y;
  endfunction

  function automatic state_t ref_round(input state_t s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v, o;
    state_t      res;
    for (int w = 0; w < 5; w++) x[w] = s[w];
    if (r < 12) x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
    for (int j = 0; j < 64; j++) begin
      v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      o = SBOX[v];
      for (int w = 0; w < 5; w++) y[w][j] = o[4 - w];
    end
    for (int w = 0; w < 5; w++) res[w] = y[w] ^ rotr(y[w], ROT_A[w]) ^ rotr(y[w], ROT_B[w]);
    return res;
  endfunction

  task automatic check(input string tag, input state_t got, input state_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one edge worth of inputs, advances the model, then samples 1 ns after the edge.
  task automatic step(input logic r_rst, input logic r_en, input logic r_mode,
                      input logic [3:0] r_rnd, input state_t r_pin, input string tag);
    rst  = r_rst;
    en   = r_en;
    mode = r_mode;
    rnd  = r_rnd;
    pin  = r_pin;
    if (r_rst)      model = '0;
    else if (r_en)  model = ref_round(r_mode ? r_pin : model, int'(r_rnd));
    @(posedge clk);
    #1;
    check(tag, pout, model);
  endtask

  function automatic state_t rand_state();
    state_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  initial begin
    state_t p12_in;
    state_t zero_rc;
    rst = 1'b1; en = 1'b0; mode = 1'b0; rnd = '0; pin = '0;
    model = '0;

    step(1'b1, 1'b1, 1'b1, 4'($urandom_range(0, 15)), rand_state(), "reset");
    check("reset_zero", pout, '0);

    step(1'b0, 1'b1, 1'b1, 4'd0, '0, "zero_round0");
    check("zero_round0_const", pout,
          {64'h001E0F00000000F0, 64'h00000001E0000770, 64'h3FFFFFFFFFFFFF74,
           64'h3C780000000000F0, 64'h0000000000000000});

    saved = pout;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'(i % 2), 4'($urandom_range(0, 15)), rand_state(), "hold");
      check("hold_const", pout, saved);
    end

    p12_in = {64'h00001000808C0001, 64'h6CB10AD9CA912F80, 64'h691AED630E81901F,
              64'h0C4C36A20853217C, 64'h46487B3E06D9D7A8};
    step(1'b0, 1'b1, 1'b1, 4'd0, p12_in, "p12_load");
    for (int r = 1; r < 12; r++)
      step(1'b0, 1'b1, 1'b0, 4'(r), rand_state(), "p12_round");

    zero_rc = {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0};
    for (int r = 12; r < 16; r++) begin
      step(1'b0, 1'b1, 1'b1, 4'(r), '0, "no_const");
      check("no_const_value", pout, zero_rc);
    end

    step(1'b0, 1'b1, 1'b1, 4'd0, rand_state(), "mid_load");
    for (int r = 1; r <= 5; r++)
      step(1'b0, 1'b1, 1'b0, 4'(r), rand_state(), "mid_round");
    step(1'b1, 1'b1, 1'b0, 4'd6, rand_state(), "mid_reset");
    check("mid_reset_zero", pout, '0);
    step(1'b0, 1'b1, 1'b0, 4'd6, rand_state(), "after_reset_r6");
    check("after_reset_r6_ref", pout, ref_round('0, 6));

    for (int i = 0; i < 300; i++)
      step(1'(($urandom() % 20) == 0), 1'(($urandom() % 4) != 0), 1'(($urandom() % 3) == 0),
           4'($urandom_range(0, 15)), rand_state(), "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
